key_entry_debounce: RTL and testbench
=====================================

// Module: key_entry_debounce
// PURPOSE
//  Front end of the password entry path. Synchronises the raw DE10 push-button and
//  the 4 slide switches, then debounces the button. Emits one single-cycle en_key
//  strobe per clean press, with the switch nibble captured on key, to the downstream
//  key-counting/compare stage. Presses are edge events: holding the button never
//  produces a second strobe.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable clocks required (10 ms @ 50 MHz); legal range >= 2
//  BTN_ACTIVE_LOW   1       1: btn_in low means pressed (DE10 KEYx); 0: high means pressed
//  CNT_W (local)    $clog2(DEBOUNCE_CYCLES)  debounce counter width
// PORTS
//  clk        in   1  system clock; single clock domain
//  rst        in   1  asynchronous, active-high reset
//  btn_in     in   1  raw push-button pin, asynchronous, bouncy
//  sw_in      in   4  raw slide switches, asynchronous
//  en_key     out  1  one-cycle strobe: one debounced press accepted
//  key        out  4  switch nibble captured with the last en_key; held until the next strobe
//  btn_level  out  1  debounced button level, 1 = pressed (high in PRESSED/REL_WAIT)
// BEHAVIOUR
//  Reset: async assert, sync use. On rst: en_key=0, key=0, btn_level=0, state=IDLE,
//   cnt=0. Both sync stages of the button path load the released level; switch sync
//   stages load 0.
//  Synchroniser: 2 flops on btn_in and on each sw_in bit. p = synced btn XOR BTN_ACTIVE_LOW.
//  FSM, all registered:
//   IDLE      p=1 -> PRESS_WAIT, cnt=0.
//   PRESS_WAIT p=0 -> IDLE, cnt=0 (bounce rejected, no strobe).
//             p=1, cnt<D-1 -> cnt+1.
//             p=1, cnt==D-1 -> PRESSED; en_key=1 and key=sw_sync in the same update.
//   PRESSED   en_key=0 from here on. p=0 -> REL_WAIT, cnt=0.
//   REL_WAIT  p=1 -> PRESSED, no strobe (release bounce).
//             p=0, cnt<D-1 -> cnt+1.
//             p=0, cnt==D-1 -> IDLE.
//   (D = DEBOUNCE_CYCLES)
//  Latency: btn_in stable pressed before rising edge E0 -> en_key high after edge
//   E0+D+2, i.e. D+3 edges including E0, for exactly 1 cycle.
//  key: sampled from sw_sync on the strobe edge only. Switch changes at any other
//   time never alter key. The switches are not debounced; the user sets them before
//   pressing.
//  btn_level = 1 in PRESSED and REL_WAIT, else 0.
//  Minimum press-to-press spacing for two strobes: D pressed + D released + 3 cycles.
//  Counter saturation: cnt never exceeds D-1 and never wraps.
//  Reset mid-operation: any state -> IDLE immediately, no strobe. A button held
//   through reset release is seen as a new press and strobes after D+3 edges.
//  en_key never asserts on 2 consecutive cycles. No other strobe source exists.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
//  1 Clean press: sw_in=4'b0101, btn_in 1->0, held 20 clk -> en_key high 1 cycle,
//    7 edges after change; key=4'b0101; btn_level=1; exactly one strobe.
//  2 Bounce: btn_in low 3 clk, high 1, low 3, high -> no en_key;
//    key stays at prior value; btn_level=0.
//  3 Release bounce: press as in 1, then high 2 clk, low 2, high 10 -> exactly one
//    en_key total; btn_level falls after 4 stable released cycles (+sync).
//  4 Two presses: sw=4'h3 press/release, then sw=4'hA press -> two strobes,
//    key=4'h3 then 4'hA; changing sw while held leaves key=4'hA.
//  5 Reset mid-debounce: assert rst at PRESS_WAIT cnt=2 -> outputs 0 at once;
//    button held through deassert -> strobe 7 edges after deassert.
//  6 Long hold: btn_in low 1000 clk -> exactly one en_key; btn_level=1 throughout.

Source files
------------

// File: rtl/key_entry_debounce.sv
// rtl/key_entry_debounce.sv - synchronise and debounce the entry button, strobe en_key with the switch nibble
module key_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic [3:0] sw_in,
  output logic       en_key,
  output logic [3:0] key,
  output logic       btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_REL_WAIT
  } state_e;

  logic       btn_s1_q, btn_s2_q;
  logic [3:0] sw_s1_q, sw_s2_q;
  logic       pressed;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            en_key_q, en_key_d;
  logic [3:0]      key_q, key_d;
  logic            btn_level_q, btn_level_d;

  // Button sync flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= BTN_ACTIVE_LOW;
      btn_s2_q <= BTN_ACTIVE_LOW;
      sw_s1_q  <= 4'd0;
      sw_s2_q  <= 4'd0;
    end else begin
      btn_s1_q <= btn_in;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_in;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign pressed = btn_s2_q ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      en_key_q    <= 1'b0;
      key_q       <= 4'd0;
      btn_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_key_q    <= en_key_d;
      key_q       <= key_d;
      btn_level_q <= btn_level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pressed) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!pressed) begin
          state_d = S_REL_WAIT;
          cnt_d   = '0;
        end
      end
      S_REL_WAIT: begin
        if (pressed) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The strobe fires only on the single PRESS_WAIT -> PRESSED transition.
  always_comb begin
    en_key_d    = (state_q == S_PRESS_WAIT) && pressed && (cnt_q == CNT_MAX);
    key_d       = en_key_d ? sw_s2_q : key_q;
    btn_level_d = (state_d == S_PRESSED) || (state_d == S_REL_WAIT);
  end

  assign en_key    = en_key_q;
  assign key       = key_q;
  assign btn_level = btn_level_q;

endmodule

// File: tb/tb_key_entry_debounce.sv
// tb/tb_key_entry_debounce.sv - randomized and directed bench against a run-length debounce model
module tb_key_entry_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic [3:0] sw_in;
  logic       en_key;
  logic [3:0] key;
  logic       btn_level;

  key_entry_debounce #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_in     (sw_in),
    .en_key    (en_key),
    .key       (key),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  logic prev_en = 1'b0;

  // Model: inputs seen two edges late; level flips after D+1 consecutive opposite samples.
  logic       m_hb1, m_hb2;
  logic [3:0] m_sh1, m_sh2;
  logic       m_level;
  int         m_run;
  logic       m_en;
  logic [3:0] m_key;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hb1 = 1'b1; m_hb2 = 1'b1;
    m_sh1 = 4'd0; m_sh2 = 4'd0;
    m_level = 1'b0; m_run = 0; m_en = 1'b0; m_key = 4'd0;
  endtask

  task automatic model_edge();
    logic p;
    p    = ~m_hb2;
    m_en = 1'b0;
    if (p != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = p;
        m_run   = 0;
        if (p) begin
          m_en  = 1'b1;
          m_key = m_sh2;
        end
      end
    end else begin
      m_run = 0;
    end
    m_hb2 = m_hb1; m_hb1 = btn_in;
    m_sh2 = m_sh1; m_sh1 = sw_in;
  endtask

  task automatic check_outputs();
    chk("en_key", en_key, m_en);
    chk("key", key, m_key);
    chk("btn_level", btn_level, m_level);
    chk("no_back_to_back", prev_en & en_key, 0);
    prev_en = en_key;
    if (en_key) strobe_cnt++;
  endtask

  task automatic step(input logic b, input logic [3:0] s);
    btn_in = b;
    sw_in  = s;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic rst_assert();
    rst = 1'b1;
    model_reset();
    prev_en = 1'b0;
    #1;
    chk("rst_en_key", en_key, 0);
    chk("rst_key", key, 0);
    chk("rst_btn_level", btn_level, 0);
  endtask

  int n0, lat, lvl_ok;
  logic [3:0] k1;

  initial begin
    btn_in = 1'b1;
    sw_in  = 4'd0;
    rst    = 1'b0;
    #2;
    rst_assert();
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 4'd0);

    // Clean press with latency measurement
    n0 = strobe_cnt; lat = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0101);
      if (en_key && lat == 0) lat = i + 1;
    end
    chk("t1_latency", 32'(lat), 7);
    chk("t1_strobes", 32'(strobe_cnt - n0), 1);
    chk("t1_key", key, 4'b0101);
    chk("t1_level", btn_level, 1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0101);

    // Press bounce
    n0 = strobe_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111);
    step(1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111);
    chk("t2_strobes", 32'(strobe_cnt - n0), 0);
    chk("t2_key", key, 4'b0101);
    chk("t2_level", btn_level, 0);

    // Release bounce
    n0 = strobe_cnt;
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0101);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0101);
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0101);
    chk("t3_level_held", btn_level, 1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0101);
      if (!btn_level && lat == 0) lat = i + 1;
    end
    chk("t3_release_latency", 32'(lat), 7);
    chk("t3_strobes", 32'(strobe_cnt - n0), 1);

    // Two presses, switch change while held
    n0 = strobe_cnt;
    for (int i = 0; i < 20; i++) step(1'b0, 4'h3);
    k1 = key;
    for (int i = 0; i < 10; i++) step(1'b1, 4'h3);
    for (int i = 0; i < 10; i++) step(1'b0, 4'hA);
    for (int i = 0; i < 10; i++) step(1'b0, 4'hF);
    chk("t4_key_first", k1, 4'h3);
    chk("t4_key_second", key, 4'hA);
    chk("t4_strobes", 32'(strobe_cnt - n0), 2);
    for (int i = 0; i < 10; i++) step(1'b1, 4'hF);

    // Reset during PRESS_WAIT, button held through release
    for (int i = 0; i < 5; i++) step(1'b0, 4'h6);
    rst_assert();
    for (int i = 0; i < 3; i++) step(1'b0, 4'h6);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'h6);
      if (en_key && lat == 0) lat = i + 1;
    end
    chk("t5_latency", 32'(lat), 7);
    chk("t5_key", key, 4'h6);
    // Reset while PRESSED must drop level and key at once
    rst_assert();
    step(1'b1, 4'h6);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 4'h6);

    // Long hold
    n0 = strobe_cnt; lvl_ok = 1;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 4'h9);
      if (i >= 7 && !btn_level) lvl_ok = 0;
    end
    chk("t6_strobes", 32'(strobe_cnt - n0), 1);
    chk("t6_level_throughout", 32'(lvl_ok), 1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'h9);

    // Random bouncy segments with occasional reset
    for (int seg = 0; seg < 300; seg++) begin
      logic b;
      logic [3:0] s;
      int len;
      b = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
        step(b, s);
      end
      if ($urandom_range(0, 99) == 0) begin
        rst_assert();
        step(b, s);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
